// File: rtl/fp_norm_round_pipe_if.sv
// ---------------------------------------------------------------------------
// fp_norm_round_pipe_if
// Bundles the upstream (in_*) and downstream (out_*) handshake/data signals
// of the normalise/round pipeline.
//
// Handshake semantics (both sides): a beat transfers on a rising clock edge
// where valid & ready are both high. A producer holding valid high keeps its
// data stable until that transfer; ready may depend combinationally on the
// consumer's own downstream ready.
//
// Signals:
//   in_valid/in_ready          upstream handshake
//   in_sign, in_exp, in_mant   raw add/sub result (carry, hidden, frac, G, R, S)
//   in_rm                      rounding mode 0=RNE 1=RTZ 2=RUP 3=RDN
//   out_valid/out_ready        downstream handshake
//   out_result                 packed {sign, exp, frac}
//   out_overflow/underflow/inexact/zero  result flags
// Modports:
//   master  - drives the beat in and accepts results (upstream + downstream)
//   slave   - the pipeline itself
// ---------------------------------------------------------------------------
interface fp_norm_round_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [MAN_W+4:0]       in_mant;
    logic [1:0]             in_rm;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_result;
    logic                   out_overflow;
    logic                   out_underflow;
    logic                   out_inexact;
    logic                   out_zero;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow,
               out_inexact, out_zero
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow,
               out_inexact, out_zero
    );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// ---------------------------------------------------------------------------
// fp_norm_round_pipe
// Two-stage floating-point normaliser and rounder placed after the adder's
// add/sub stage. Stage 1 normalises (right shift on carry, leading-zero left
// shift otherwise, zero/underflow detection). Stage 2 rounds under the beat's
// own rounding mode, handles overflow and packs {sign, exp, frac} + flags.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (drops in-flight beats, clears outputs)
//   bus    fp_norm_round_pipe_if.slave (upstream and downstream handshakes)
// ---------------------------------------------------------------------------
module fp_norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_norm_round_pipe_if.slave   bus
);
    localparam int MW  = MAN_W + 5;           // raw mantissa width
    localparam int NW  = MAN_W + 4;           // normalised mantissa width
    localparam int XW  = EXP_W + 1;           // internal exponent width
    localparam int LZW = $clog2(MAN_W + 4);   // holds lz up to MAN_W+3

    localparam logic [XW-1:0] EXP_OVF = {1'b0, {EXP_W{1'b1}}};

    // ---------------- pipeline registers ----------------
    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic [1:0]           s1_rm_q;
    logic [XW-1:0]        s1_exp_q;
    logic [NW-1:0]        s1_mant_q;
    logic                 s1_zero_q;
    logic                 s1_uf_q;

    logic                 out_valid_q;
    logic [EXP_W+MAN_W:0] out_result_q;
    logic                 out_overflow_q;
    logic                 out_underflow_q;
    logic                 out_inexact_q;
    logic                 out_zero_q;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    // ---------------- stage 1: normalise ----------------
    logic                 carry;
    logic                 mant_zero;
    logic [LZW-1:0]       lz;
    logic                 uf_d;
    logic                 zero_d;
    logic [NW-1:0]        mant_d;
    logic [XW-1:0]        exp_d;

    always_comb begin
        carry     = bus.in_mant[MW-1];
        mant_zero = (bus.in_mant == '0);

        // Leading zeros over [MAN_W+3:1]; ascending scan so the highest set
        // bit wins. All-zero field gives MAN_W+3 (only S may be set).
        lz = LZW'(MAN_W + 3);
        for (int j = 1; j <= MAN_W + 3; j++) begin
            if (bus.in_mant[j]) begin
                lz = LZW'(MAN_W + 3 - j);
            end
        end

        uf_d = !carry && !mant_zero &&
               ({{(32-EXP_W){1'b0}}, bus.in_exp} <= {{(32-LZW){1'b0}}, lz});
        zero_d = mant_zero || uf_d;

        if (carry) begin
            // R moves into the sticky slot and S is shifted out, so both OR in.
            mant_d = {bus.in_mant[MW-1:2], bus.in_mant[1] | bus.in_mant[0]};
            exp_d  = {1'b0, bus.in_exp} + XW'(1);
        end else begin
            mant_d = bus.in_mant[NW-1:0] << lz;
            exp_d  = {1'b0, bus.in_exp} - XW'(lz);
        end

        if (zero_d) begin
            mant_d = '0;
            exp_d  = '0;
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic [MAN_W-1:0]     frac;
    logic                 g_bit;
    logic                 rs_bit;
    logic                 inexact_r;
    logic                 round_up;
    logic                 frac_cout;
    logic [MAN_W-1:0]     frac_r;
    logic [XW-1:0]        exp_r;
    logic                 to_inf;
    logic [EXP_W+MAN_W:0] result_d;
    logic                 ovf_d;
    logic                 unf_d;
    logic                 inx_d;
    logic                 zro_d;

    always_comb begin
        frac      = s1_mant_q[NW-2:3];
        g_bit     = s1_mant_q[2];
        rs_bit    = s1_mant_q[1] | s1_mant_q[0];
        inexact_r = g_bit | rs_bit;

        case (s1_rm_q)
            2'd0:    round_up = g_bit & (rs_bit | frac[0]);
            2'd1:    round_up = 1'b0;
            2'd2:    round_up = inexact_r & !s1_sign_q;
            default: round_up = inexact_r & s1_sign_q;
        endcase

        {frac_cout, frac_r} = {1'b0, frac} + (MAN_W+1)'(round_up);
        exp_r = s1_exp_q + XW'(frac_cout);

        to_inf = (s1_rm_q == 2'd0) ||
                 (s1_rm_q == 2'd2 && !s1_sign_q) ||
                 (s1_rm_q == 2'd3 && s1_sign_q);

        result_d = {s1_sign_q, exp_r[EXP_W-1:0], frac_r};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = inexact_r;
        zro_d    = 1'b0;

        if (s1_zero_q) begin
            result_d = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
            unf_d    = s1_uf_q;
            inx_d    = s1_uf_q;
            zro_d    = 1'b1;
        end else if (exp_r >= EXP_OVF) begin
            ovf_d = 1'b1;
            inx_d = 1'b1;
            if (to_inf) begin
                result_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                result_d = {s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_sign_q       <= 1'b0;
            s1_rm_q         <= '0;
            s1_exp_q        <= '0;
            s1_mant_q       <= '0;
            s1_zero_q       <= 1'b0;
            s1_uf_q         <= 1'b0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
            out_inexact_q   <= 1'b0;
            out_zero_q      <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign_q <= bus.in_sign;
                    s1_rm_q   <= bus.in_rm;
                    s1_exp_q  <= exp_d;
                    s1_mant_q <= mant_d;
                    s1_zero_q <= zero_d;
                    s1_uf_q   <= uf_d;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_result_q    <= result_d;
                    out_overflow_q  <= ovf_d;
                    out_underflow_q <= unf_d;
                    out_inexact_q   <= inx_d;
                    out_zero_q      <= zro_d;
                end
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = out_result_q;
    assign bus.out_overflow  = out_overflow_q;
    assign bus.out_underflow = out_underflow_q;
    assign bus.out_inexact   = out_inexact_q;
    assign bus.out_zero      = out_zero_q;
endmodule
